// File: rtl/cache_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cache_mem_ctrl
//  Purpose  : Block-transfer controller between the cache and main memory.
//             On a miss it optionally writes back a dirty block word by word,
//             then refills the requested block and returns it to the cache.
//             Each memory word access is closed by DONE_CNT rising edges of
//             mem_done.
//  Ports    : clock, reset            - system clock, async active-high reset
//             req_valid/req_ready     - miss request handshake (ready in IDLE)
//             req_dirty, wb_addr,
//             wb_data, fill_addr      - request payload, captured on accept
//             fill_valid, fill_data   - one-cycle completion pulse + block
//             mem_read_or_write,
//             mem_address,
//             mem_write_data          - memory command (1 = write)
//             mem_done, mem_read_data - memory completion pulses + read word
//  Revision : 1.0 - initial release
// ============================================================================
module cache_mem_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int WORDS    = 4,
    parameter int DONE_CNT = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_dirty,
    input  logic [ADDR_W-1:0]     wb_addr,
    input  logic [32*WORDS-1:0]   wb_data,
    input  logic [ADDR_W-1:0]     fill_addr,
    output logic                  fill_valid,
    output logic [32*WORDS-1:0]   fill_data,
    output logic                  mem_read_or_write,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [31:0]           mem_write_data,
    input  logic                  mem_done,
    input  logic [31:0]           mem_read_data
);

    // Address split: {block, word index, byte offset}. WORDS is a power of two.
    localparam int c_IDX_W = $clog2(WORDS);
    localparam int c_OFF_W = c_IDX_W + 2;
    localparam int c_BLK_W = ADDR_W - c_OFF_W;
    localparam int c_CNT_W = $clog2(DONE_CNT + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST    = c_CNT_W'(DONE_CNT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST    = c_IDX_W'(WORDS - 1);
    localparam logic [ADDR_W-1:0]  c_DETOUR_FLIP = ADDR_W'(1) << c_OFF_W;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DETOUR = 3'd1;
    localparam logic [2:0] S_WB     = 3'd2;
    localparam logic [2:0] S_FILL   = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    logic [2:0]            r_state;
    logic [c_IDX_W-1:0]    r_word_idx;
    logic [c_CNT_W-1:0]    r_done_cnt;
    logic                  r_done_q;
    logic                  r_dirty;
    logic [c_BLK_W-1:0]    r_wb_blk;
    logic [c_BLK_W-1:0]    r_fill_blk;
    logic [32*WORDS-1:0]   r_wb_data;

    logic                  w_rise;
    logic                  w_cnt_last;
    logic                  w_word_last;
    logic [c_IDX_W-1:0]    w_idx_next;
    logic [ADDR_W-1:0]     w_first_addr;
    logic                  w_first_hit;
    logic                  w_unused;

    // Block offset bits of the request addresses carry no information.
    assign w_unused = ^{wb_addr[c_OFF_W-1:0], fill_addr[c_OFF_W-1:0]};

    assign w_rise      = mem_done & ~r_done_q;
    assign w_cnt_last  = (r_done_cnt == c_CNT_LAST);
    assign w_word_last = (r_word_idx == c_IDX_LAST);
    assign w_idx_next  = r_word_idx + c_IDX_W'(1);

    // The memory only starts an access when address or direction changes.
    // If the first access of a new request repeats what is already driven,
    // a dummy read of a neighbouring block is inserted first.
    assign w_first_addr = req_dirty ? {wb_addr[ADDR_W-1:c_OFF_W],   c_OFF_W'(0)}
                                    : {fill_addr[ADDR_W-1:c_OFF_W], c_OFF_W'(0)};
    assign w_first_hit  = (w_first_addr == mem_address) &&
                          (req_dirty == mem_read_or_write);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state           <= S_IDLE;
            r_word_idx        <= '0;
            r_done_cnt        <= '0;
            r_done_q          <= 1'b0;
            r_dirty           <= 1'b0;
            r_wb_blk          <= '0;
            r_fill_blk        <= '0;
            r_wb_data         <= '0;
            req_ready         <= 1'b1;
            fill_valid        <= 1'b0;
            fill_data         <= '0;
            mem_read_or_write <= 1'b0;
            mem_address       <= '0;
            mem_write_data    <= '0;
        end else begin
            r_done_q   <= mem_done;
            fill_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_dirty    <= req_dirty;
                        r_wb_blk   <= wb_addr[ADDR_W-1:c_OFF_W];
                        r_fill_blk <= fill_addr[ADDR_W-1:c_OFF_W];
                        r_wb_data  <= wb_data;
                        r_word_idx <= '0;
                        r_done_cnt <= '0;
                        req_ready  <= 1'b0;
                        if (w_first_hit) begin
                            r_state           <= S_DETOUR;
                            mem_address       <= w_first_addr ^ c_DETOUR_FLIP;
                            mem_read_or_write <= 1'b0;
                        end else if (req_dirty) begin
                            r_state           <= S_WB;
                            mem_address       <= w_first_addr;
                            mem_read_or_write <= 1'b1;
                            mem_write_data    <= wb_data[31:0];
                        end else begin
                            r_state           <= S_FILL;
                            mem_address       <= w_first_addr;
                            mem_read_or_write <= 1'b0;
                        end
                    end
                end

                S_DETOUR: begin
                    if (w_rise) begin
                        if (w_cnt_last) begin
                            r_done_cnt <= '0;
                            if (r_dirty) begin
                                r_state           <= S_WB;
                                mem_address       <= {r_wb_blk, c_OFF_W'(0)};
                                mem_read_or_write <= 1'b1;
                                mem_write_data    <= r_wb_data[31:0];
                            end else begin
                                r_state           <= S_FILL;
                                mem_address       <= {r_fill_blk, c_OFF_W'(0)};
                                mem_read_or_write <= 1'b0;
                            end
                        end else begin
                            r_done_cnt <= r_done_cnt + c_CNT_W'(1);
                        end
                    end
                end

                S_WB: begin
                    if (w_rise) begin
                        if (w_cnt_last) begin
                            r_done_cnt <= '0;
                            if (w_word_last) begin
                                r_word_idx        <= '0;
                                r_state           <= S_FILL;
                                mem_address       <= {r_fill_blk, c_OFF_W'(0)};
                                mem_read_or_write <= 1'b0;
                            end else begin
                                r_word_idx     <= w_idx_next;
                                mem_address    <= {r_wb_blk, w_idx_next, 2'b00};
                                mem_write_data <= r_wb_data[{w_idx_next, 5'd0} +: 32];
                            end
                        end else begin
                            r_done_cnt <= r_done_cnt + c_CNT_W'(1);
                        end
                    end
                end

                S_FILL: begin
                    if (w_rise) begin
                        // Every rise overwrites the word; the last one stands.
                        fill_data[{r_word_idx, 5'd0} +: 32] <= mem_read_data;
                        if (w_cnt_last) begin
                            r_done_cnt <= '0;
                            if (w_word_last) begin
                                // Address wraps to the block base, so a repeat
                                // miss on this block is seen as a hit later.
                                r_word_idx  <= '0;
                                mem_address <= {r_fill_blk, c_OFF_W'(0)};
                                r_state     <= S_RESP;
                                fill_valid  <= 1'b1;
                            end else begin
                                r_word_idx  <= w_idx_next;
                                mem_address <= {r_fill_blk, w_idx_next, 2'b00};
                            end
                        end else begin
                            r_done_cnt <= r_done_cnt + c_CNT_W'(1);
                        end
                    end
                end

                S_RESP: begin
                    r_state   <= S_IDLE;
                    req_ready <= 1'b1;
                end

                default: begin
                    r_state   <= S_IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_mem_ctrl
//  Purpose  : Self-checking bench for cache_mem_ctrl with a behavioural
//             memory that pulses mem_done DONE_CNT times per new access and a
//             block-level model of expected accesses and refill data.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cache_mem_ctrl;

    localparam int ADDR_W   = 10;
    localparam int WORDS    = 4;
    localparam int DONE_CNT = 4;

    typedef struct packed {
        logic [9:0]  a;
        logic        w;
        logic [31:0] d;
    } acc_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_dirty = 1'b0;
    logic [9:0]    wb_addr = '0;
    logic [127:0]  wb_data = '0;
    logic [9:0]    fill_addr = '0;
    logic          fill_valid;
    logic [127:0]  fill_data;
    logic          mem_read_or_write;
    logic [9:0]    mem_address;
    logic [31:0]   mem_write_data;
    logic          mem_done = 1'b0;
    logic [31:0]   mem_read_data = '0;

    int            n_vec = 0;
    int            n_mis = 0;
    int            n_fv  = 0;

    logic [31:0]   mem [256];
    acc_t          tr_q[$];
    bit            m_noise = 1'b0;
    logic [10:0]   m_key = '0;
    int            m_left = 0;
    int            m_wait = 0;
    int            m_hi = 0;

    logic [10:0]   last_drv;
    logic [127:0]  last_fill;

    cache_mem_ctrl #(
        .ADDR_W   (ADDR_W),
        .WORDS    (WORDS),
        .DONE_CNT (DONE_CNT)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_dirty         (req_dirty),
        .wb_addr           (wb_addr),
        .wb_data           (wb_data),
        .fill_addr         (fill_addr),
        .fill_valid        (fill_valid),
        .fill_data         (fill_data),
        .mem_read_or_write (mem_read_or_write),
        .mem_address       (mem_address),
        .mem_write_data    (mem_write_data),
        .mem_done          (mem_done),
        .mem_read_data     (mem_read_data)
    );

    always #5 clock = ~clock;

    // Memory: a change of (direction, address) starts a new access that emits
    // DONE_CNT pulses, each 1-3 cycles high with 1-3 cycle low gaps.
    always @(negedge clock) begin
        if (fill_valid === 1'b1) n_fv++;
        if (reset) begin
            mem_done = 1'b0;
            m_key    = {mem_read_or_write, mem_address};
            m_left   = 0;
        end else if (m_noise) begin
            mem_done      = 1'($urandom_range(0, 1));
            mem_read_data = $urandom;
            m_key         = {mem_read_or_write, mem_address};
            m_left        = 1;
            m_hi          = 1;
        end else if ({mem_read_or_write, mem_address} !== m_key) begin
            m_key    = {mem_read_or_write, mem_address};
            mem_done = 1'b0;
            m_left   = DONE_CNT;
            m_wait   = $urandom_range(1, 3);
            tr_q.push_back('{a: mem_address, w: mem_read_or_write, d: mem_write_data});
        end else if (mem_done) begin
            m_hi--;
            if (m_hi == 0) begin
                mem_done = 1'b0;
                m_left--;
                m_wait = $urandom_range(1, 3);
            end
        end else if (m_left > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                mem_done = 1'b1;
                m_hi     = $urandom_range(1, 3);
                if (mem_read_or_write) mem[mem_address[9:2]] = mem_write_data;
                mem_read_data = mem[mem_address[9:2]];
            end
        end
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_txn(input bit dirty, input logic [9:0] wa, input logic [127:0] wd,
                          input logic [9:0] fa, input bit toggle, input bit scramble,
                          input string tag);
        acc_t         exp_q[$];
        logic [127:0] exp_fill;
        logic [10:0]  first;
        bit           seen;
        int           n;
        for (int i = 0; i < WORDS; i++)
            exp_fill[32*i +: 32] = (dirty && wa[9:4] == fa[9:4]) ? wd[32*i +: 32]
                                                                 : mem[{fa[9:4], i[1:0]}];
        first = dirty ? {1'b1, wa[9:4], 4'h0} : {1'b0, fa[9:4], 4'h0};
        if (first == last_drv)
            exp_q.push_back('{a: first[9:0] ^ 10'h010, w: 1'b0, d: 32'h0});
        if (dirty)
            for (int i = 0; i < WORDS; i++)
                exp_q.push_back('{a: {wa[9:4], i[1:0], 2'b00}, w: 1'b1, d: wd[32*i +: 32]});
        for (int i = 0; i < WORDS; i++)
            exp_q.push_back('{a: {fa[9:4], i[1:0], 2'b00}, w: 1'b0, d: 32'h0});
        exp_q.push_back('{a: {fa[9:4], 4'h0}, w: 1'b0, d: 32'h0});

        chk({tag, "/ready_idle"}, {127'b0, req_ready}, 128'd1);
        tr_q.delete();
        n_fv      = 0;
        req_valid = 1'b1;
        req_dirty = dirty;
        wb_addr   = wa;
        wb_data   = wd;
        fill_addr = fa;
        step();
        req_valid = 1'b0;
        if (scramble) begin
            wb_data   = {$urandom, $urandom, $urandom, $urandom};
            wb_addr   = 10'($urandom);
            fill_addr = 10'($urandom);
            req_dirty = 1'($urandom);
        end
        chk({tag, "/ready_busy"}, {127'b0, req_ready}, 128'd0);

        seen = 1'b0;
        for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
            if (toggle && tr_q.size() < exp_q.size() - 2)
                req_valid = 1'($urandom_range(0, 1));
            else
                req_valid = 1'b0;
            step();
            seen = (fill_valid === 1'b1);
        end
        req_valid = 1'b0;
        chk({tag, "/fill_valid_seen"}, {127'b0, seen}, 128'd1);
        chk({tag, "/fill_data"}, fill_data, exp_fill);
        step();
        chk({tag, "/fill_valid_drop"}, {127'b0, fill_valid}, 128'd0);
        chk({tag, "/ready_back"}, {127'b0, req_ready}, 128'd1);
        step();
        step();
        chk({tag, "/fill_pulses"}, 128'(n_fv), 128'd1);
        chk({tag, "/access_count"}, 128'(tr_q.size()), 128'(exp_q.size()));
        n = (tr_q.size() < exp_q.size()) ? tr_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (exp_q[i].w)
                chk({tag, "/access"}, 128'(tr_q[i]), 128'(exp_q[i]));
            else
                chk({tag, "/access"}, 128'({tr_q[i].a, tr_q[i].w}), 128'({exp_q[i].a, exp_q[i].w}));
        end
        if (dirty)
            for (int i = 0; i < WORDS; i++)
                chk({tag, "/mem_written"}, 128'(mem[{wa[9:4], i[1:0]}]), 128'(wd[32*i +: 32]));
        last_drv  = {1'b0, fa[9:4], 4'h0};
        last_fill = fill_data;
        req_dirty = 1'b0;
    endtask

    initial begin
        logic [127:0] first_fill;
        logic [127:0] wd;
        logic [9:0]   wa;
        logic [9:0]   fa;
        bit           seen;
        bit           all_ready;
        logic [9:0]   held_addr;

        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0]  = 32'h55555555; mem[1]  = 32'h0000000F;
        mem[2]  = 32'h0000000E; mem[3]  = 32'h0000000A;
        mem[16] = 32'hCCCCCCCC; mem[17] = 32'hEEEEEEEE;
        mem[18] = 32'h55555555; mem[19] = 32'hBBBBBBBB;
        last_drv = 11'h000;

        reset = 1'b1;
        step();
        step();
        chk("rst/ready",     {127'b0, req_ready},         128'd1);
        chk("rst/fill_valid",{127'b0, fill_valid},        128'd0);
        chk("rst/fill_data", fill_data,                   128'd0);
        chk("rst/mem_rw",    {127'b0, mem_read_or_write}, 128'd0);
        chk("rst/mem_addr",  128'(mem_address),           128'd0);
        chk("rst/mem_wdata", 128'(mem_write_data),        128'd0);
        reset = 1'b0;
        step();

        // Clean miss of block 0x040.
        do_txn(1'b0, 10'h000, 128'h0, 10'h040, 1'b0, 1'b0, "clean");
        chk("clean/const", last_fill, 128'hBBBBBBBB_55555555_EEEEEEEE_CCCCCCCC);

        // Dirty miss, victim and refill on the same block.
        do_txn(1'b1, 10'h100, {32'd4, 32'd3, 32'd2, 32'd1}, 10'h100, 1'b0, 1'b0, "dirty");
        chk("dirty/const", last_fill, {32'd4, 32'd3, 32'd2, 32'd1});

        // Back-to-back fill of the same block: second one detours.
        do_txn(1'b0, 10'h000, 128'h0, 10'h040, 1'b0, 1'b0, "b2b_a");
        first_fill = last_fill;
        do_txn(1'b0, 10'h000, 128'h0, 10'h040, 1'b0, 1'b0, "b2b_b");
        chk("b2b/same_data", last_fill, first_fill);

        // Reset in the middle of a write-back, after word 1 completed.
        req_valid = 1'b1; req_dirty = 1'b1; wb_addr = 10'h200;
        wb_data = {$urandom, $urandom, $urandom, $urandom}; fill_addr = 10'h280;
        step();
        req_valid = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 2000 && !seen; cyc++) begin
            step();
            seen = (mem_address === 10'h208) && (mem_read_or_write === 1'b1);
        end
        chk("midwb/reached_word2", {127'b0, seen}, 128'd1);
        reset = 1'b1;
        #1;
        chk("midwb/ready",      {127'b0, req_ready},         128'd1);
        chk("midwb/fill_valid", {127'b0, fill_valid},        128'd0);
        chk("midwb/fill_data",  fill_data,                   128'd0);
        chk("midwb/mem_rw",     {127'b0, mem_read_or_write}, 128'd0);
        chk("midwb/mem_addr",   128'(mem_address),           128'd0);
        chk("midwb/mem_wdata",  128'(mem_write_data),        128'd0);
        step();
        step();
        reset = 1'b0;
        req_dirty = 1'b0;
        step();
        last_drv = 11'h000;
        do_txn(1'b0, 10'h000, 128'h0, 10'h000, 1'b0, 1'b0, "after_rst");
        chk("after_rst/const", last_fill, 128'h0000000A_0000000E_0000000F_55555555);

        // mem_done noise while idle must not start anything.
        n_fv = 0;
        all_ready = 1'b1;
        held_addr = mem_address;
        m_noise = 1'b1;
        for (int c = 0; c < 24; c++) begin
            step();
            all_ready &= (req_ready === 1'b1);
        end
        m_noise = 1'b0;
        step(); step(); step();
        chk("idle_noise/ready",   {127'b0, all_ready}, 128'd1);
        chk("idle_noise/no_fill", 128'(n_fv),          128'd0);
        chk("idle_noise/addr",    128'(mem_address),   128'(held_addr));

        // req_valid toggled while busy.
        do_txn(1'b1, 10'h0C0, {$urandom, $urandom, $urandom, $urandom}, 10'h180, 1'b1, 1'b0, "toggle");

        // Request inputs changed right after acceptance.
        do_txn(1'b1, 10'h300, {$urandom, $urandom, $urandom, $urandom}, 10'h340, 1'b1, 1'b1, "scramble");

        // Randomized misses, biased toward same-block and repeat-fill cases.
        for (int t = 0; t < 16; t++) begin
            wa = 10'($urandom) & 10'h3F0;
            wd = {$urandom, $urandom, $urandom, $urandom};
            case ($urandom_range(0, 3))
                0:       fa = wa;
                1:       fa = last_drv[9:0];
                default: fa = 10'($urandom);
            endcase
            do_txn(1'($urandom), wa | 10'($urandom_range(0, 15)), wd, fa,
                   1'($urandom), 1'($urandom), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_mem_ctrl.md
Name: cache_mem_ctrl

Overview:
- Block-transfer controller between the cache and the main memory model; the memory sits directly downstream and is driven only by this block.
- On a cache miss it optionally writes back a dirty 4-word block, then refills the requested 4-word block and returns it to the cache.
- Sequencing is paced by the memory's `done` pulses, counted word by word.

Parameters:
- ADDR_W, 10, byte address width on both cache and memory sides.
- WORDS, 4, 32-bit words per block; fixed by the 16-byte block.
- DONE_CNT, 4, `done` rising edges the memory emits per access; all are consumed before advancing.

Ports:
- clock  in  1  single system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  miss request from cache; accepted when req_ready=1.
- req_ready  out  1  high only in IDLE.
- req_dirty  in  1  1 = write back wb_data before refill.
- wb_addr  in  ADDR_W  byte address of the victim block; bits [3:0] ignored.
- wb_data  in  32*WORDS  victim block; word i = bits [32i+31:32i].
- fill_addr  in  ADDR_W  byte address of the missing block; bits [3:0] ignored.
- fill_valid  out  1  one-cycle pulse when fill_data is complete.
- fill_data  out  32*WORDS  refilled block, same word packing as wb_data.
- mem_read_or_write  out  1  1 = write word to memory, 0 = read word from memory.
- mem_address  out  ADDR_W  word byte address; [1:0] always 0.
- mem_write_data  out  32  write word.
- mem_done  in  1  memory completion pulse; asynchronous to clock, width at least one clock period.
- mem_read_data  in  32  read word; valid while mem_done=1.

Behaviour:
- Reset values:
  - state=IDLE, word_idx=0, done_cnt=0.
  - req_ready=1, fill_valid=0, fill_data=0.
  - mem_read_or_write=0, mem_address=0, mem_write_data=0.
  - done_q=0.
- Done detection:
  - done_q registers mem_done.
  - rise = mem_done & ~done_q.
  - Rises outside WB/FILL/DETOUR are ignored.
- On acceptance (IDLE & req_valid):
  - Capture req_dirty, wb_addr[9:4], wb_data and fill_addr[9:4].
  - Later changes to these inputs have no effect.
- Word address = {block[9:4], word_idx[1:0], 2'b00}; words are issued in order 0,1,2,3.
- States:
  - IDLE: mem_* hold last driven values.
    - Accept → WB if dirty, else FILL.
    - First-access check: if the first access's (address, direction) equals the currently driven (mem_address, mem_read_or_write), go to DETOUR instead.
  - DETOUR:
    - Drive read of the first-access address ^ 10'h010.
    - Count DONE_CNT rises and discard the data.
    - Then go to WB or FILL as captured.
  - WB:
    - mem_read_or_write=1, mem_write_data=wb word[word_idx].
    - After DONE_CNT rises: word_idx+1 and done_cnt=0.
    - After word 3: word_idx=0 → FILL.
  - FILL:
    - mem_read_or_write=0.
    - On each rise, latch mem_read_read_data into fill_data word[word_idx]; the last latch of a word wins.
    - After DONE_CNT rises: advance. After word 3 → RESP.
  - RESP:
    - fill_valid=1 for exactly one cycle → IDLE.
    - fill_data holds until overwritten by the next FILL.
- mem_address and mem_read_or_write change only on the cycle that advances a word or state, and stay stable while counting.
- Latency: set by the memory. Controller overhead is 1 cycle for accept, plus 1 cycle per word advance, plus 1 cycle for RESP.
- wb_addr equal to fill_addr is legal: the block is written first, and the refill returns the written data.
- Reset mid-operation:
  - Immediate return to IDLE with the reset values above.
  - A partially written block is left as-is in memory.
  - A partial fill_data is cleared to 0.
- req_valid while busy is not accepted; the cache holds it until req_ready=1.

Test Plan:
- Clean miss, fill_addr=10'h040, memory words 16..19 = CCCCCCCC, EEEEEEEE, 55555555, BBBBBBBB
  → 16 mem_done rises; mem_address sequence 040, 044, 048, 04C, all reads.
  → fill_valid single pulse; fill_data = {BBBBBBBB,55555555,EEEEEEEE,CCCCCCCC}.
- Dirty miss, wb_addr=10'h100, wb_data={4,3,2,1}, fill_addr=10'h100
  → writes to 100, 104, 108, 10C with data 1, 2, 3, 4, then reads.
  → fill_data={4,3,2,1}.
- Back-to-back fill of 10'h040 twice
  → second request enters DETOUR (read 050, 4 rises discarded) before issuing 040.
  → Both fills return identical data.
- Reset asserted mid-WB after word 1
  → outputs at reset values immediately; req_ready=1.
  → A following clean fill of 10'h000 returns {A,E,F,55555555}.
- mem_done pulses while IDLE, and req_valid toggled during FILL
  → no state change, no extra acceptance, exactly one fill_valid.
- Inputs changed after acceptance (wb_data, fill_addr)
  → transfers use the captured values only.
